// File: rtl/arf_err_stats_if.sv
// Beat, control and result-read bundle between an ARF filter-pair source and arf_err_stats.
// The block is the slave; a controller or bench drives the master side.
interface arf_err_stats_if #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 32,
   parameter int SUM_W = 64,
   parameter int SQ_W  = 96
);
   logic                     start;
   logic [CNT_W-1:0]         n_samples;
   logic                     in_valid;
   logic                     in_ready;
   logic signed [WIDTH-1:0]  approx_a;
   logic signed [WIDTH-1:0]  exact_a;
   logic signed [WIDTH-1:0]  approx_b;
   logic signed [WIDTH-1:0]  exact_b;
   logic                     rd_ch;
   logic                     busy;
   logic                     done;
   logic signed [SUM_W-1:0]  err_sum;
   logic [SQ_W-1:0]          err_sq_sum;
   logic [CNT_W-1:0]         n_err0;
   logic [CNT_W-1:0]         n_err1;
   logic [WIDTH:0]           max_abs_err;
   logic                     ovf;

   modport master (
      output start, n_samples, in_valid, approx_a, exact_a, approx_b, exact_b, rd_ch,
      input  in_ready, busy, done, err_sum, err_sq_sum, n_err0, n_err1, max_abs_err, ovf
   );

   modport slave (
      input  start, n_samples, in_valid, approx_a, exact_a, approx_b, exact_b, rd_ch,
      output in_ready, busy, done, err_sum, err_sq_sum, n_err0, n_err1, max_abs_err, ovf
   );
endinterface

// File: rtl/arf_err_stats.sv
// Error-statistics engine for the approximate/accurate ARF pair: per channel it accumulates
// sum(err), sum(err^2), ER0/ER1 counts and max|err| over a programmed number of beats.
module arf_err_stats #(
   parameter int WIDTH     = 32,
   parameter int ER_THRESH = 8,
   parameter int CNT_W     = 32,
   parameter int SUM_W     = 64,
   parameter int SQ_W      = 96
) (
   input  logic            clk,
   input  logic            rst_n,
   arf_err_stats_if.slave  bus
);
   localparam int EW = WIDTH + 1;
   localparam int PW = 2 * WIDTH + 2;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t                   state_q, state_d;
   logic                     clr, accept, ready_d, in_ready_q;
   logic [CNT_W-1:0]         acc_q, acc_d, n_q, n_d;

   logic signed [WIDTH-1:0]  apx_p0 [2];
   logic signed [WIDTH-1:0]  exa_p0 [2];
   logic signed [EW-1:0]     err_p0 [2];
   logic [EW-1:0]            abs_p0 [2];

   logic                     vld_p1;
   logic signed [EW-1:0]     err_p1 [2];
   logic [EW-1:0]            abs_p1 [2];
   logic                     er0_p1 [2];
   logic                     er1_p1 [2];
   logic [PW-1:0]            sq_p1  [2];
   logic [SUM_W:0]           sum_nx [2];
   logic [SQ_W:0]            sqs_nx [2];

   logic signed [SUM_W-1:0]  sum_q  [2];
   logic [SQ_W-1:0]          sqs_q  [2];
   logic [CNT_W-1:0]         e0_q   [2];
   logic [CNT_W-1:0]         e1_q   [2];
   logic [EW-1:0]            max_q  [2];
   logic                     ovf_q;

   // Returns {saturated, value}; clamps to the signed SUM_W range
   function automatic logic [SUM_W:0] sat_add_sum(input logic signed [SUM_W-1:0] acc,
                                                  input logic signed [EW-1:0] e);
      logic signed [SUM_W:0] s;
      s = {acc[SUM_W-1], acc} + {{(SUM_W+1-EW){e[EW-1]}}, e};
      if (s[SUM_W] != s[SUM_W-1])
         return {1'b1, s[SUM_W], {(SUM_W-1){~s[SUM_W]}}};
      return {1'b0, s[SUM_W-1:0]};
   endfunction

   function automatic logic [SQ_W:0] sat_add_sq(input logic [SQ_W-1:0] acc,
                                                input logic [PW-1:0] p);
      logic [SQ_W:0] s;
      s = {1'b0, acc} + {{(SQ_W+1-PW){1'b0}}, p};
      if (s[SQ_W])
         return {(SQ_W+1){1'b1}};
      return s;
   endfunction

   assign accept = bus.in_valid && in_ready_q;

   always_comb begin
      state_d = state_q;
      clr     = 1'b0;
      acc_d   = acc_q;
      n_d     = n_q;
      case (state_q)
         IDLE, DONE: if (bus.start) begin
            clr     = 1'b1;
            n_d     = bus.n_samples;
            acc_d   = '0;
            state_d = (bus.n_samples == '0) ? DONE : RUN;
         end
         RUN: if (accept) begin
            acc_d = acc_q + CNT_W'(1);
            if (acc_d == n_q) state_d = DRAIN;
         end
         DRAIN: if (!vld_p1) state_d = DONE;
         default: state_d = IDLE;
      endcase
      ready_d = (state_d == RUN) && (acc_d < n_d);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         acc_q      <= '0;
         n_q        <= '0;
         in_ready_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         acc_q      <= acc_d;
         n_q        <= n_d;
         in_ready_q <= ready_d;
      end
   end

   assign apx_p0[0] = bus.approx_a;
   assign exa_p0[0] = bus.exact_a;
   assign apx_p0[1] = bus.approx_b;
   assign exa_p0[1] = bus.exact_b;

   always_comb begin
      for (int c = 0; c < 2; c++) begin
         err_p0[c] = {apx_p0[c][WIDTH-1], apx_p0[c]} - {exa_p0[c][WIDTH-1], exa_p0[c]};
         abs_p0[c] = err_p0[c][EW-1] ? $unsigned(-err_p0[c]) : $unsigned(err_p0[c]);
      end
   end

   // ---- S1: register err, |err| and the ER0/ER1 flags ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) vld_p1 <= 1'b0;
      else        vld_p1 <= accept;
   end

   always_ff @(posedge clk) begin
      for (int c = 0; c < 2; c++) begin
         err_p1[c] <= err_p0[c];
         abs_p1[c] <= abs_p0[c];
         er0_p1[c] <= (apx_p0[c] != exa_p0[c]);
         er1_p1[c] <= (apx_p0[c][WIDTH-1:ER_THRESH] != exa_p0[c][WIDTH-1:ER_THRESH]);
      end
   end

   // ---- S2: square and fold into the saturating accumulators ----
   always_comb begin
      for (int c = 0; c < 2; c++) begin
         sq_p1[c]  = {{(PW-EW){1'b0}}, abs_p1[c]} * {{(PW-EW){1'b0}}, abs_p1[c]};
         sum_nx[c] = sat_add_sum(sum_q[c], err_p1[c]);
         sqs_nx[c] = sat_add_sq(sqs_q[c], sq_p1[c]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
         for (int c = 0; c < 2; c++) begin
            sum_q[c] <= '0;
            sqs_q[c] <= '0;
            e0_q[c]  <= '0;
            e1_q[c]  <= '0;
            max_q[c] <= '0;
         end
      end else if (clr) begin
         ovf_q <= 1'b0;
         for (int c = 0; c < 2; c++) begin
            sum_q[c] <= '0;
            sqs_q[c] <= '0;
            e0_q[c]  <= '0;
            e1_q[c]  <= '0;
            max_q[c] <= '0;
         end
      end else if (vld_p1) begin
         ovf_q <= ovf_q | sum_nx[0][SUM_W] | sum_nx[1][SUM_W] | sqs_nx[0][SQ_W] | sqs_nx[1][SQ_W];
         for (int c = 0; c < 2; c++) begin
            sum_q[c] <= sum_nx[c][SUM_W-1:0];
            sqs_q[c] <= sqs_nx[c][SQ_W-1:0];
            e0_q[c]  <= e0_q[c] + {{(CNT_W-1){1'b0}}, er0_p1[c]};
            e1_q[c]  <= e1_q[c] + {{(CNT_W-1){1'b0}}, er1_p1[c]};
            if (abs_p1[c] > max_q[c]) max_q[c] <= abs_p1[c];
         end
      end
   end

   assign bus.in_ready    = in_ready_q;
   assign bus.busy        = (state_q == RUN) || (state_q == DRAIN);
   assign bus.done        = (state_q == DONE);
   assign bus.err_sum     = bus.rd_ch ? sum_q[1] : sum_q[0];
   assign bus.err_sq_sum  = bus.rd_ch ? sqs_q[1] : sqs_q[0];
   assign bus.n_err0      = bus.rd_ch ? e0_q[1]  : e0_q[0];
   assign bus.n_err1      = bus.rd_ch ? e1_q[1]  : e1_q[0];
   assign bus.max_abs_err = bus.rd_ch ? max_q[1] : max_q[0];
   assign bus.ovf         = ovf_q;
endmodule

// File: tb/tb_arf_err_stats.sv
// Directed bench for arf_err_stats: a default instance plus a narrow-accumulator (SUM_W=34)
// instance sharing the same stimulus so err_sum saturation can be observed.
module tb_arf_err_stats;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int vecs = 0;
   int errs = 0;

   logic               start = 1'b0;
   logic [31:0]        n_samples = '0;
   logic               in_valid = 1'b0;
   logic signed [31:0] aa = '0, ea = '0, ab = '0, eb = '0;
   logic               rd_ch = 1'b0;

   arf_err_stats_if #(.WIDTH(32), .CNT_W(32), .SUM_W(64), .SQ_W(96)) ifm ();
   arf_err_stats_if #(.WIDTH(32), .CNT_W(32), .SUM_W(34), .SQ_W(96)) ifs ();

   assign ifm.start = start;     assign ifs.start = start;
   assign ifm.n_samples = n_samples; assign ifs.n_samples = n_samples;
   assign ifm.in_valid = in_valid;   assign ifs.in_valid = in_valid;
   assign ifm.approx_a = aa;     assign ifs.approx_a = aa;
   assign ifm.exact_a = ea;      assign ifs.exact_a = ea;
   assign ifm.approx_b = ab;     assign ifs.approx_b = ab;
   assign ifm.exact_b = eb;      assign ifs.exact_b = eb;
   assign ifm.rd_ch = rd_ch;     assign ifs.rd_ch = rd_ch;

   arf_err_stats #(.WIDTH(32), .ER_THRESH(8), .CNT_W(32), .SUM_W(64), .SQ_W(96))
      u_dut (.clk(clk), .rst_n(rst_n), .bus(ifm.slave));
   arf_err_stats #(.WIDTH(32), .ER_THRESH(8), .CNT_W(32), .SUM_W(34), .SQ_W(96))
      u_dut_narrow (.clk(clk), .rst_n(rst_n), .bus(ifs.slave));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [31:0] n);
      start = 1'b1;
      n_samples = n;
      step();
      start = 1'b0;
   endtask

   task automatic send_beat(input logic signed [31:0] a0, e0, a1, e1);
      logic got;
      got = 1'b0;
      aa = a0; ea = e0; ab = a1; eb = e1;
      in_valid = 1'b1;
      for (int i = 0; i < 20 && !got; i++) begin
         got = ifm.in_ready;
         step();
      end
      in_valid = 1'b0;
      vecs++;
      if (!got) begin errs++; $display("FAIL beat_accept: in_ready=0 required 1 within 20 cycles"); end
   endtask

   task automatic wait_done();
      for (int i = 0; i < 20 && !ifm.done; i++) step();
      vecs++;
      if (ifm.done !== 1'b1) begin errs++; $display("FAIL done_timeout: done=%0b required 1", ifm.done); end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      step();
      vecs++; if (ifm.in_ready !== 1'b0) begin errs++; $display("FAIL rst_in_ready got %0b exp 0", ifm.in_ready); end
      vecs++; if (ifm.busy !== 1'b0) begin errs++; $display("FAIL rst_busy got %0b exp 0", ifm.busy); end
      vecs++; if (ifm.done !== 1'b0) begin errs++; $display("FAIL rst_done got %0b exp 0", ifm.done); end
      vecs++; if (ifm.ovf !== 1'b0) begin errs++; $display("FAIL rst_ovf got %0b exp 0", ifm.ovf); end
      vecs++; if (ifm.err_sum !== 64'sd0) begin errs++; $display("FAIL rst_sum got %0d exp 0", ifm.err_sum); end
      vecs++; if (ifm.err_sq_sum !== 96'd0) begin errs++; $display("FAIL rst_sq got %0d exp 0", ifm.err_sq_sum); end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_zero_error();
      rd_ch = 1'b0;
      do_start(4);
      vecs++; if (ifm.in_ready !== 1'b1) begin errs++; $display("FAIL zero_ready_after_start got %0b exp 1", ifm.in_ready); end
      vecs++; if (ifm.busy !== 1'b1) begin errs++; $display("FAIL zero_busy got %0b exp 1", ifm.busy); end
      send_beat(5, 5, -7, -7);
      send_beat(32'sh7FFFFFFF, 32'sh7FFFFFFF, 32'sh80000000, 32'sh80000000);
      send_beat(0, 0, 123, 123);
      send_beat(-1, -1, 256, 256);
      vecs++; if (ifm.in_ready !== 1'b0) begin errs++; $display("FAIL zero_ready_after_last got %0b exp 0", ifm.in_ready); end
      vecs++; if (ifm.done !== 1'b0) begin errs++; $display("FAIL zero_done_k got %0b exp 0", ifm.done); end
      step();
      vecs++; if (ifm.done !== 1'b0) begin errs++; $display("FAIL zero_done_k1 got %0b exp 0", ifm.done); end
      step();
      vecs++; if (ifm.done !== 1'b1) begin errs++; $display("FAIL zero_done_k2 got %0b exp 1", ifm.done); end
      vecs++; if (ifm.busy !== 1'b0) begin errs++; $display("FAIL zero_busy_k2 got %0b exp 0", ifm.busy); end
      for (int c = 0; c < 2; c++) begin
         rd_ch = c[0];
         #1;
         vecs++; if (ifm.err_sum !== 64'sd0) begin errs++; $display("FAIL zero_sum ch%0d got %0d exp 0", c, ifm.err_sum); end
         vecs++; if (ifm.err_sq_sum !== 96'd0) begin errs++; $display("FAIL zero_sq ch%0d got %0d exp 0", c, ifm.err_sq_sum); end
         vecs++; if (ifm.n_err0 !== 32'd0) begin errs++; $display("FAIL zero_err0 ch%0d got %0d exp 0", c, ifm.n_err0); end
         vecs++; if (ifm.n_err1 !== 32'd0) begin errs++; $display("FAIL zero_err1 ch%0d got %0d exp 0", c, ifm.n_err1); end
         vecs++; if (ifm.max_abs_err !== 33'd0) begin errs++; $display("FAIL zero_max ch%0d got %0d exp 0", c, ifm.max_abs_err); end
      end
      vecs++; if (ifm.ovf !== 1'b0) begin errs++; $display("FAIL zero_ovf got %0b exp 0", ifm.ovf); end
   endtask

   task automatic test_single_beat();
      do_start(1);
      send_beat(10, 3, -5, 5);
      wait_done();
      rd_ch = 1'b0;
      #1;
      vecs++; if (ifm.err_sum !== 64'sd7) begin errs++; $display("FAIL single_a_sum got %0d exp 7", ifm.err_sum); end
      vecs++; if (ifm.err_sq_sum !== 96'd49) begin errs++; $display("FAIL single_a_sq got %0d exp 49", ifm.err_sq_sum); end
      vecs++; if (ifm.n_err0 !== 32'd1) begin errs++; $display("FAIL single_a_err0 got %0d exp 1", ifm.n_err0); end
      vecs++; if (ifm.n_err1 !== 32'd0) begin errs++; $display("FAIL single_a_err1 got %0d exp 0", ifm.n_err1); end
      vecs++; if (ifm.max_abs_err !== 33'd7) begin errs++; $display("FAIL single_a_max got %0d exp 7", ifm.max_abs_err); end
      rd_ch = 1'b1;
      #1;
      vecs++; if (ifm.err_sum !== -64'sd10) begin errs++; $display("FAIL single_b_sum got %0d exp -10", ifm.err_sum); end
      vecs++; if (ifm.err_sq_sum !== 96'd100) begin errs++; $display("FAIL single_b_sq got %0d exp 100", ifm.err_sq_sum); end
      vecs++; if (ifm.n_err0 !== 32'd1) begin errs++; $display("FAIL single_b_err0 got %0d exp 1", ifm.n_err0); end
      vecs++; if (ifm.n_err1 !== 32'd1) begin errs++; $display("FAIL single_b_err1 got %0d exp 1", ifm.n_err1); end
      vecs++; if (ifm.max_abs_err !== 33'd10) begin errs++; $display("FAIL single_b_max got %0d exp 10", ifm.max_abs_err); end
   endtask

   task automatic test_er1_threshold();
      rd_ch = 1'b0;
      do_start(1);
      send_beat(32'sh100, 32'sh1FF, 0, 0);
      wait_done();
      vecs++; if (ifm.n_err0 !== 32'd1) begin errs++; $display("FAIL er1_same_hi_err0 got %0d exp 1", ifm.n_err0); end
      vecs++; if (ifm.n_err1 !== 32'd0) begin errs++; $display("FAIL er1_same_hi_err1 got %0d exp 0", ifm.n_err1); end
      vecs++; if (ifm.err_sum !== -64'sd255) begin errs++; $display("FAIL er1_same_hi_sum got %0d exp -255", ifm.err_sum); end
      do_start(1);
      vecs++; if (ifm.done !== 1'b0) begin errs++; $display("FAIL er1_done_drop got %0b exp 0", ifm.done); end
      send_beat(32'sh100, 32'sh0FF, 0, 0);
      wait_done();
      vecs++; if (ifm.n_err0 !== 32'd1) begin errs++; $display("FAIL er1_diff_hi_err0 got %0d exp 1", ifm.n_err0); end
      vecs++; if (ifm.n_err1 !== 32'd1) begin errs++; $display("FAIL er1_diff_hi_err1 got %0d exp 1", ifm.n_err1); end
      vecs++; if (ifm.err_sum !== 64'sd1) begin errs++; $display("FAIL er1_diff_hi_sum got %0d exp 1", ifm.err_sum); end
   endtask

   task automatic test_back_to_back();
      logic [6:0] pat;
      int accepted;
      pat = 7'b1110101;
      accepted = 0;
      rd_ch = 1'b0;
      aa = 2; ea = 0; ab = 9; eb = 9;
      do_start(3);
      for (int i = 0; i < 7; i++) begin
         in_valid = pat[i];
         start = (i == 1);
         n_samples = (i == 1) ? 32'd9 : 32'd3;
         if (in_valid && ifm.in_ready) accepted++;
         step();
      end
      start = 1'b0;
      in_valid = 1'b0;
      vecs++; if (accepted !== 3) begin errs++; $display("FAIL bp_accepted got %0d exp 3", accepted); end
      vecs++; if (ifm.in_ready !== 1'b0) begin errs++; $display("FAIL bp_ready_low got %0b exp 0", ifm.in_ready); end
      wait_done();
      vecs++; if (ifm.err_sum !== 64'sd6) begin errs++; $display("FAIL bp_sum got %0d exp 6", ifm.err_sum); end
      vecs++; if (ifm.err_sq_sum !== 96'd12) begin errs++; $display("FAIL bp_sq got %0d exp 12", ifm.err_sq_sum); end
      vecs++; if (ifm.n_err0 !== 32'd3) begin errs++; $display("FAIL bp_err0 got %0d exp 3", ifm.n_err0); end
      vecs++; if (ifm.max_abs_err !== 33'd2) begin errs++; $display("FAIL bp_max got %0d exp 2", ifm.max_abs_err); end
      rd_ch = 1'b1;
      #1;
      vecs++; if (ifm.n_err0 !== 32'd0) begin errs++; $display("FAIL bp_b_err0 got %0d exp 0", ifm.n_err0); end
      rd_ch = 1'b0;
   endtask

   task automatic test_extremes();
      logic [95:0] e;
      e = 96'hFFFF_FFFF;
      rd_ch = 1'b0;
      do_start(1);
      send_beat(32'sh7FFFFFFF, 32'sh80000000, 0, 0);
      wait_done();
      vecs++; if (ifm.err_sum !== 64'sh0000_0000_FFFF_FFFF) begin errs++; $display("FAIL ext1_sum got %0h exp ffffffff", ifm.err_sum); end
      vecs++; if (ifm.max_abs_err !== 33'h0_FFFF_FFFF) begin errs++; $display("FAIL ext1_max got %0h exp ffffffff", ifm.max_abs_err); end
      vecs++; if (ifm.err_sq_sum !== 96'hFFFF_FFFE_0000_0001) begin errs++; $display("FAIL ext1_sq got %0h exp fffffffe00000001", ifm.err_sq_sum); end
      vecs++; if (ifm.ovf !== 1'b0) begin errs++; $display("FAIL ext1_ovf got %0b exp 0", ifm.ovf); end
      vecs++; if (ifs.ovf !== 1'b0) begin errs++; $display("FAIL ext1_narrow_ovf got %0b exp 0", ifs.ovf); end
      do_start(3);
      for (int i = 0; i < 3; i++) send_beat(32'sh7FFFFFFF, 32'sh80000000, 0, 0);
      wait_done();
      vecs++; if (ifm.err_sum !== 64'sh0000_0002_FFFF_FFFD) begin errs++; $display("FAIL ext3_sum got %0h exp 2fffffffd", ifm.err_sum); end
      vecs++; if (ifm.err_sq_sum !== e * e * 96'd3) begin errs++; $display("FAIL ext3_sq got %0h exp %0h", ifm.err_sq_sum, e * e * 96'd3); end
      vecs++; if (ifm.ovf !== 1'b0) begin errs++; $display("FAIL ext3_ovf got %0b exp 0", ifm.ovf); end
      vecs++; if (ifs.err_sum !== 34'sh1_FFFF_FFFF) begin errs++; $display("FAIL ext3_narrow_sat got %0h exp 1ffffffff", ifs.err_sum); end
      vecs++; if (ifs.ovf !== 1'b1) begin errs++; $display("FAIL ext3_narrow_ovf got %0b exp 1", ifs.ovf); end
   endtask

   task automatic test_reset_midrun();
      rd_ch = 1'b0;
      do_start(5);
      send_beat(4, 1, 0, 0);
      send_beat(4, 1, 0, 0);
      step();
      rst_n = 1'b0;
      #1;
      vecs++; if (ifm.busy !== 1'b0) begin errs++; $display("FAIL mrst_busy got %0b exp 0", ifm.busy); end
      vecs++; if (ifm.in_ready !== 1'b0) begin errs++; $display("FAIL mrst_ready got %0b exp 0", ifm.in_ready); end
      vecs++; if (ifm.done !== 1'b0) begin errs++; $display("FAIL mrst_done got %0b exp 0", ifm.done); end
      vecs++; if (ifm.err_sum !== 64'sd0) begin errs++; $display("FAIL mrst_sum got %0d exp 0", ifm.err_sum); end
      vecs++; if (ifm.n_err0 !== 32'd0) begin errs++; $display("FAIL mrst_err0 got %0d exp 0", ifm.n_err0); end
      vecs++; if (ifm.max_abs_err !== 33'd0) begin errs++; $display("FAIL mrst_max got %0d exp 0", ifm.max_abs_err); end
      #2;
      rst_n = 1'b1;
      step();
      do_start(0);
      vecs++; if (ifm.done !== 1'b1) begin errs++; $display("FAIL n0_done got %0b exp 1", ifm.done); end
      vecs++; if (ifm.busy !== 1'b0) begin errs++; $display("FAIL n0_busy got %0b exp 0", ifm.busy); end
      vecs++; if (ifm.in_ready !== 1'b0) begin errs++; $display("FAIL n0_ready got %0b exp 0", ifm.in_ready); end
      vecs++; if (ifm.err_sum !== 64'sd0) begin errs++; $display("FAIL n0_sum got %0d exp 0", ifm.err_sum); end
      vecs++; if (ifm.err_sq_sum !== 96'd0) begin errs++; $display("FAIL n0_sq got %0d exp 0", ifm.err_sq_sum); end
   endtask

   initial begin
      test_reset();
      test_zero_error();
      test_single_beat();
      test_er1_threshold();
      test_back_to_back();
      test_extremes();
      test_reset_midrun();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
